// File: rtl/id_ex_reg_pkg.sv
// Shared decode constants: ALUOp classes, opcodes and default widths used by
// the control decoder and the ID/EX pipeline register.
package id_ex_reg_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int CNT_W_DEF      = 16;
    localparam int FUNCT_W        = 10;

    typedef enum logic [1:0] {
        ALUOP_RTYPE = 2'b00,
        ALUOP_IMM   = 2'b01
    } aluop_e;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic       RegWrite;
        logic       MemToReg;
        logic       MemRead;
        logic       MemWrite;
        logic       Branch;
        logic       ALUSrc;
        logic [1:0] ALUOp;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/id_ex_reg_pipe_reg.sv
// Generic WIDTH-bit pipeline flop: async reset, clear wins over stall, stall holds.
module pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clear_i)       q_d = '0;
        else if (!stall_i) q_d = d_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) q_q <= '0;
        else       q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: operands, addresses, funct, PC and decoder control,
// with stall/flush and a saturating count of bubbles entering EX.
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    input  logic                  RegWrite_i,
    input  logic                  MemToReg_i,
    input  logic                  MemRead_i,
    input  logic                  MemWrite_i,
    input  logic                  Branch_i,
    input  logic                  ALUSrc_i,
    input  logic [1:0]            ALUOp_i,
    input  logic [DATA_W-1:0]     RS1data_i,
    input  logic [DATA_W-1:0]     RS2data_i,
    input  logic [DATA_W-1:0]     Imm_i,
    input  logic [DATA_W-1:0]     PC_i,
    input  logic [9:0]            Funct_i,
    input  logic [REG_ADDR_W-1:0] RS1addr_i,
    input  logic [REG_ADDR_W-1:0] RS2addr_i,
    input  logic [REG_ADDR_W-1:0] RDaddr_i,
    output logic                  valid_o,
    output logic                  RegWrite_o,
    output logic                  MemToReg_o,
    output logic                  MemRead_o,
    output logic                  MemWrite_o,
    output logic                  Branch_o,
    output logic                  ALUSrc_o,
    output logic [1:0]            ALUOp_o,
    output logic [DATA_W-1:0]     RS1data_o,
    output logic [DATA_W-1:0]     RS2data_o,
    output logic [DATA_W-1:0]     Imm_o,
    output logic [DATA_W-1:0]     PC_o,
    output logic [9:0]            Funct_o,
    output logic [REG_ADDR_W-1:0] RS1addr_o,
    output logic [REG_ADDR_W-1:0] RS2addr_o,
    output logic [REG_ADDR_W-1:0] RDaddr_o,
    output logic [CNT_W-1:0]      bubble_cnt_o
);

    localparam int DW = 4 * DATA_W + FUNCT_W + 3 * REG_ADDR_W;

    logic [DW-1:0] data_d, data_q;
    ctrl_t         ctrl_d, ctrl_q;
    logic          ctrl_clr;

    assign data_d = {RS1data_i, RS2data_i, Imm_i, PC_i, Funct_i,
                     RS1addr_i, RS2addr_i, RDaddr_i};
    assign ctrl_d = '{RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i,
                      Branch_i, ALUSrc_i, ALUOp_i};

    // An invalid slot only zeroes control when it is actually loaded; a stall must still hold.
    assign ctrl_clr = flush_i | (!valid_i & !stall_i);

    pipe_reg #(.WIDTH(DW)) u_data (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .stall_i (stall_i),
        .clear_i (flush_i),
        .d_i     (data_d),
        .q_o     (data_q)
    );

    pipe_reg #(.WIDTH(CTRL_W)) u_ctrl (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .stall_i (stall_i),
        .clear_i (ctrl_clr),
        .d_i     (ctrl_d),
        .q_o     (ctrl_q)
    );

    assign {RS1data_o, RS2data_o, Imm_o, PC_o, Funct_o,
            RS1addr_o, RS2addr_o, RDaddr_o} = data_q;
    assign {RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o,
            Branch_o, ALUSrc_o, ALUOp_o} = ctrl_q;

    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bubble;

    assign bubble = flush_i | (!stall_i & !valid_i);

    always_comb begin
        valid_d = valid_q;
        if (flush_i)       valid_d = 1'b0;
        else if (!stall_i) valid_d = valid_i;

        cnt_d = cnt_q;
        if (bubble && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o      = valid_q;
    assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized bench for id_ex_reg against a behavioural next-state model,
// plus directed literal checks for reset, stall, flush, invalid load and saturation.
module tb_id_ex_reg;

    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 0, flush_i = 0, valid_i = 0;
    logic        RegWrite_i = 0, MemToReg_i = 0, MemRead_i = 0, MemWrite_i = 0;
    logic        Branch_i = 0, ALUSrc_i = 0;
    logic [1:0]  ALUOp_i = 0;
    logic [31:0] RS1data_i = 0, RS2data_i = 0, Imm_i = 0, PC_i = 0;
    logic [9:0]  Funct_i = 0;
    logic [4:0]  RS1addr_i = 0, RS2addr_i = 0, RDaddr_i = 0;

    logic        valid_o, RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, Branch_o, ALUSrc_o;
    logic [1:0]  ALUOp_o;
    logic [31:0] RS1data_o, RS2data_o, Imm_o, PC_o;
    logic [9:0]  Funct_o;
    logic [4:0]  RS1addr_o, RS2addr_o, RDaddr_o;
    logic [CW-1:0] bubble_cnt_o;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    id_ex_reg #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
        .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .Branch_i(Branch_i), .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i),
        .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i), .PC_i(PC_i),
        .Funct_i(Funct_i), .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
        .valid_o(valid_o), .RegWrite_o(RegWrite_o), .MemToReg_o(MemToReg_o),
        .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .Branch_o(Branch_o),
        .ALUSrc_o(ALUSrc_o), .ALUOp_o(ALUOp_o),
        .RS1data_o(RS1data_o), .RS2data_o(RS2data_o), .Imm_o(Imm_o), .PC_o(PC_o),
        .Funct_o(Funct_o), .RS1addr_o(RS1addr_o), .RS2addr_o(RS2addr_o), .RDaddr_o(RDaddr_o),
        .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk = ~clk;

    // Expected register contents, as a plain record.
    typedef struct {
        bit        valid;
        bit [7:0]  ctrl;
        bit [31:0] rs1, rs2, imm, pc;
        bit [9:0]  funct;
        bit [4:0]  a1, a2, rd;
        int        cnt;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t cleared();
        mdl_t z;
        z.valid = 0; z.ctrl = 0; z.rs1 = 0; z.rs2 = 0; z.imm = 0; z.pc = 0;
        z.funct = 0; z.a1 = 0; z.a2 = 0; z.rd = 0; z.cnt = 0;
        return z;
    endfunction

    function automatic int sat_inc(int c);
        return (c >= CNT_MAX) ? CNT_MAX : c + 1;
    endfunction

    function automatic mdl_t next_state(mdl_t cur);
        mdl_t n = cur;
        if (flush_i) begin
            n = cleared();
            n.cnt = sat_inc(cur.cnt);
        end else if (!stall_i) begin
            n.valid = valid_i;
            n.ctrl  = valid_i ? {RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i,
                                 Branch_i, ALUSrc_i, ALUOp_i} : 8'h00;
            n.rs1 = RS1data_i; n.rs2 = RS2data_i; n.imm = Imm_i; n.pc = PC_i;
            n.funct = Funct_i; n.a1 = RS1addr_i; n.a2 = RS2addr_i; n.rd = RDaddr_i;
            if (!valid_i) n.cnt = sat_inc(cur.cnt);
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= cleared();
        else     m <= next_state(m);
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", 64'(valid_o), 64'(m.valid));
            chk("ctrl", 64'({RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o,
                             Branch_o, ALUSrc_o, ALUOp_o}), 64'(m.ctrl));
            chk("rs1", 64'(RS1data_o), 64'(m.rs1));
            chk("rs2", 64'(RS2data_o), 64'(m.rs2));
            chk("imm", 64'(Imm_o), 64'(m.imm));
            chk("pc", 64'(PC_o), 64'(m.pc));
            chk("funct", 64'(Funct_o), 64'(m.funct));
            chk("addrs", 64'({RS1addr_o, RS2addr_o, RDaddr_o}), 64'({m.a1, m.a2, m.rd}));
            chk("cnt", 64'(bubble_cnt_o), 64'(m.cnt));
        end
    end

    task automatic rnd_fields();
        {RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, Branch_i, ALUSrc_i, ALUOp_i} = 8'($urandom);
        RS1data_i = $urandom; RS2data_i = $urandom; Imm_i = $urandom; PC_i = $urandom;
        Funct_i = 10'($urandom); RS1addr_i = 5'($urandom); RS2addr_i = 5'($urandom);
        RDaddr_i = 5'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1 rst = 1;
        valid_i = 1; rnd_fields();
        @(negedge clk);
        chk("rst_valid", 64'(valid_o), 0);
        chk("rst_cnt", 64'(bubble_cnt_o), 0);
        chk("rst_rs1", 64'(RS1data_o), 0);
        chk("rst_regwrite", 64'(RegWrite_o), 0);
        chk_en = 1;
        rst = 0;

        // normal load, first edge after reset release
        rnd_fields();
        valid_i = 1; RegWrite_i = 1; ALUOp_i = 2'b00; RS1data_i = 32'h5; RDaddr_i = 5'd3;
        step();
        chk("ld_regwrite", 64'(RegWrite_o), 1);
        chk("ld_rs1", 64'(RS1data_o), 5);
        chk("ld_rd", 64'(RDaddr_o), 3);
        chk("ld_valid", 64'(valid_o), 1);
        chk("ld_cnt", 64'(bubble_cnt_o), 0);

        // stall holds for 3 edges, load on the edge after release
        PC_i = 32'h10;
        step();
        chk("st_pc0", 64'(PC_o), 32'h10);
        stall_i = 1; PC_i = 32'h14;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_hold", 64'(PC_o), 32'h10);
        end
        stall_i = 0;
        step();
        chk("st_release", 64'(PC_o), 32'h14);

        // flush with stall
        flush_i = 1; stall_i = 1; MemWrite_i = 1; valid_i = 1;
        step();
        chk("fl_valid", 64'(valid_o), 0);
        chk("fl_memwrite", 64'(MemWrite_o), 0);
        chk("fl_rs1", 64'(RS1data_o), 0);
        chk("fl_pc", 64'(PC_o), 0);
        chk("fl_cnt", 64'(bubble_cnt_o), 1);
        flush_i = 0; stall_i = 0;

        // invalid load keeps data but zeroes control
        valid_i = 0; RegWrite_i = 1; MemRead_i = 1; Imm_i = 32'hFFFF_FFF0;
        step();
        chk("inv_regwrite", 64'(RegWrite_o), 0);
        chk("inv_memread", 64'(MemRead_o), 0);
        chk("inv_imm", 64'(Imm_o), 32'hFFFF_FFF0);
        chk("inv_valid", 64'(valid_o), 0);
        chk("inv_cnt", 64'(bubble_cnt_o), 2);
        chk("model_cnt", 64'(m.cnt), 2);

        // asynchronous reset mid-stream
        valid_i = 1; RS1data_i = 32'hA5A5_0001;
        #2 rst = 1;
        #1;
        chk("arst_imm", 64'(Imm_o), 0);
        chk("arst_cnt", 64'(bubble_cnt_o), 0);
        chk("arst_valid", 64'(valid_o), 0);
        @(negedge clk);
        rst = 0;
        step();
        chk("arst_reload", 64'(RS1data_o), 32'hA5A5_0001);

        // saturation
        flush_i = 1;
        for (int i = 0; i < 17; i++) step();
        chk("sat_cnt", 64'(bubble_cnt_o), 4'hF);
        chk("model_sat", 64'(m.cnt), CNT_MAX);
        step();
        chk("sat_hold", 64'(bubble_cnt_o), 4'hF);
        flush_i = 0;

        // randomized traffic with occasional async resets
        for (int i = 0; i < 400; i++) begin
            rst = 0;
            rnd_fields();
            valid_i = ($urandom_range(0, 3) != 0);
            flush_i = ($urandom_range(0, 7) == 0);
            stall_i = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 63) == 0) begin
                #2 rst = 1;
                #1 chk("rnd_arst_cnt", 64'(bubble_cnt_o), 0);
            end
            @(negedge clk);
        end
        rst = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
